flag_gen_unit: RTL and testbench

Producer side of the branch-condition path: computes zero, negative and equal flags from execute-stage results and holds them in architectural flag registers. It also tracks flag-setting instructions in flight between issue and writeback, so that decode stalls a conditional branch until its flags are valid. It sits between the ALU/EX stage and the branch logic unit; it drives that unit's `zeroF`, `negF` and `eqF` inputs.

---
 rtl/vetris_flag_pkg.sv | 21 ++
 rtl/flag_gen_unit_if.sv | 33 +++
 rtl/flag_gen_unit_pend_counter.sv | 49 ++++
 rtl/flag_gen_unit.sv | 86 ++++++++
 tb/tb_flag_gen_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/vetris_flag_pkg.sv
// Shared types and helpers for the flag generation path.
// Contents: flags_t payload, FLAGS_RESET value, pend_w() sizing of the
// pending-writer counter.
package vetris_flag_pkg;

   // Architectural condition flags handed to branch logic.
   typedef struct packed {
      logic zero;
      logic neg;
      logic eq;
   } flags_t;

   // Flags after reset: a cleared result looks like zero.
   localparam flags_t FLAGS_RESET = '{zero: 1'b1, neg: 1'b0, eq: 1'b0};

   // PEND_W: counter width able to hold 0..max_pend.
   function automatic int unsigned pend_w(input int unsigned max_pend);
      return $clog2(max_pend + 1);
   endfunction

endpackage

// File: rtl/flag_gen_unit_if.sv
// Pipeline <-> flag_gen_unit bundle.
// master: EX/decode side (drives issue/retire/operands/flush, reads flags).
// slave : flag_gen_unit (reads pipeline events, drives flags and status).
interface flag_gen_unit_if #(
   parameter int unsigned DATA_W = 32
);
   logic              id_issue;
   logic              id_sets_flags;
   logic              ex_valid;
   logic              ex_sets_flags;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] alu_op_a;
   logic [DATA_W-1:0] alu_op_b;
   logic              flush;
   logic              zeroF;
   logic              negF;
   logic              eqF;
   logic              flags_ready;
   logic              issue_stall;
   logic              flag_err;

   modport master (
      output id_issue, id_sets_flags, ex_valid, ex_sets_flags,
             alu_result, alu_op_a, alu_op_b, flush,
      input  zeroF, negF, eqF, flags_ready, issue_stall, flag_err
   );

   modport slave (
      input  id_issue, id_sets_flags, ex_valid, ex_sets_flags,
             alu_result, alu_op_a, alu_op_b, flush,
      output zeroF, negF, eqF, flags_ready, issue_stall, flag_err
   );
endinterface

// File: rtl/flag_gen_unit_pend_counter.sv
// flag_pend_counter: saturating count of flag writers in flight.
// Ports: clk, rst_n; i_inc (issue event), i_dec (retire event), i_flush
// (clear to 0); o_count (registered); o_ovf_c / o_unf_c combinational
// one-cycle error pulses for an issue at MAX_PEND / a retire at 0.
module flag_pend_counter
   import vetris_flag_pkg::*;
#(
   parameter int unsigned MAX_PEND = 3,
   parameter int unsigned CNT_W    = pend_w(MAX_PEND)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   input  logic             i_dec,
   input  logic             i_flush,
   output logic [CNT_W-1:0] o_count,
   output logic             o_ovf_c,
   output logic             o_unf_c
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_next;

   // Next count; a retire with nothing outstanding is always a violation,
   // even when it shares the cycle with a flush or a new issue.
   always_comb begin
      w_next  = r_count;
      o_ovf_c = 1'b0;
      o_unf_c = i_dec && (r_count == '0);
      if (i_flush) begin
         w_next = '0;
      end else if (i_inc && !i_dec) begin
         if (r_count == CNT_MAX) o_ovf_c = 1'b1;
         else                    w_next  = r_count + CNT_W'(1);
      end else if (i_dec && !i_inc && (r_count != '0)) begin
         w_next = r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_count <= '0;
      else        r_count <= w_next;
   end

   assign o_count = r_count;

endmodule

// File: rtl/flag_gen_unit.sv
// flag_gen_unit: computes zero/neg/eq from EX results, holds them in the
// architectural flag register and tracks flag writers in flight so decode
// can hold conditional branches until their flags are valid.
// Ports: clk, rst_n (async, active low); bus (flag_gen_unit_if.slave).
// Option: define FLAG_BYPASS_EN to forward retiring EX flags combinationally
// in the retire cycle (flags and flags_ready one cycle earlier).
module flag_gen_unit
   import vetris_flag_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_PEND = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   flag_gen_unit_if.slave  bus
);

   localparam int unsigned PEND_W = pend_w(MAX_PEND);

   logic              w_retire;
   logic              w_issue;
   flags_t            w_flags;
   flags_t            w_flags_out;
   flags_t            r_flags;
   logic              r_flag_err;
   logic [PEND_W-1:0] w_count;
   logic              w_ovf;
   logic              w_unf;

   assign w_retire = bus.ex_valid & bus.ex_sets_flags;
   // A flush kills anything leaving decode in the same cycle.
   assign w_issue  = bus.id_issue & bus.id_sets_flags & ~bus.flush;

   // Flags of the retiring EX result.
   always_comb begin
      w_flags      = FLAGS_RESET;
      w_flags.zero = (bus.alu_result == '0);
      w_flags.neg  = bus.alu_result[DATA_W-1];
      w_flags.eq   = (bus.alu_op_a == bus.alu_op_b);
   end

   flag_pend_counter #(
      .MAX_PEND (MAX_PEND),
      .CNT_W    (PEND_W)
   ) u_pend (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_issue),
      .i_dec   (w_retire),
      .i_flush (bus.flush),
      .o_count (w_count),
      .o_ovf_c (w_ovf),
      .o_unf_c (w_unf)
   );

   // Flag register; EX has committed, so a retire writes even under flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags    <= FLAGS_RESET;
         r_flag_err <= 1'b0;
      end else begin
         if (w_retire) r_flags <= w_flags;
         r_flag_err <= r_flag_err | w_ovf | w_unf;
      end
   end

`ifdef FLAG_BYPASS_EN
   // Forward the retiring flags; the last outstanding writer retiring with
   // no new writer behind it makes the flags consumable this cycle.
   assign w_flags_out     = w_retire ? w_flags : r_flags;
   assign bus.flags_ready = (w_count == '0) |
                            ((w_count == PEND_W'(1)) & w_retire & ~w_issue);
`else
   assign w_flags_out     = r_flags;
   assign bus.flags_ready = (w_count == '0);
`endif

   // A retire this cycle frees a slot, so a full counter need not stall.
   assign bus.issue_stall = (w_count == PEND_W'(MAX_PEND)) & ~w_retire;

   assign bus.zeroF    = w_flags_out.zero;
   assign bus.negF     = w_flags_out.neg;
   assign bus.eqF      = w_flags_out.eq;
   assign bus.flag_err = r_flag_err;

endmodule

// File: tb/tb_flag_gen_unit.sv
// Self-checking bench for flag_gen_unit (DATA_W=32, MAX_PEND=3).
// Each cycle: inputs driven after the falling edge, the expected outputs
// pushed to a scoreboard queue, then popped and compared shortly before
// the rising edge that consumes those inputs.
module tb_flag_gen_unit;

   typedef struct {
      logic        iss, isf, exv, exsf, fl;
      logic [31:0] res, a, b;
      int          pend;
      logic        z, n, e, rdy, stall, err;
   } vec_t;

   typedef struct {
      logic z, n, e, rdy, stall, err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];
   vec_t vecs[19];

   always #5 clk = ~clk;

   flag_gen_unit_if #(.DATA_W(32)) bus ();

   flag_gen_unit #(
      .DATA_W   (32),
      .MAX_PEND (3)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic vec_t mk(logic iss, logic isf, logic exv, logic exsf,
                               logic fl, logic [31:0] res, logic [31:0] a,
                               logic [31:0] b, int pend, logic z, logic n,
                               logic e, logic rdy, logic stall, logic err);
      vec_t v;
      v.iss = iss; v.isf = isf; v.exv = exv; v.exsf = exsf; v.fl = fl;
      v.res = res; v.a = a; v.b = b; v.pend = pend;
      v.z = z; v.n = n; v.e = e; v.rdy = rdy; v.stall = stall; v.err = err;
      return v;
   endfunction

   // Expected pre-edge view; with forwarding, a retire shows its own flags.
   function automatic exp_t expect_of(vec_t v);
      exp_t x;
      x.z = v.z; x.n = v.n; x.e = v.e;
      x.rdy = v.rdy; x.stall = v.stall; x.err = v.err;
`ifdef FLAG_BYPASS_EN
      if (v.exv && v.exsf) begin
         x.z = (v.res == 32'd0);
         x.n = v.res[31];
         x.e = (v.a == v.b);
         if (v.pend == 1 && !(v.iss && v.isf && !v.fl)) x.rdy = 1'b1;
      end
`endif
      return x;
   endfunction

   task automatic check(input string name, input logic act, input logic req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
      end
   endtask

   task automatic compare_outputs(input string tag);
      exp_t x;
      if (sb.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL %s: scoreboard empty, got 1 expected 0 pending", tag);
         return;
      end
      x = sb.pop_front();
      check({tag, " zeroF"},       bus.zeroF,       x.z);
      check({tag, " negF"},        bus.negF,        x.n);
      check({tag, " eqF"},         bus.eqF,         x.e);
      check({tag, " flags_ready"}, bus.flags_ready, x.rdy);
      check({tag, " issue_stall"}, bus.issue_stall, x.stall);
      check({tag, " flag_err"},    bus.flag_err,    x.err);
   endtask

   task automatic drive(input vec_t v);
      bus.id_issue      = v.iss;
      bus.id_sets_flags = v.isf;
      bus.ex_valid      = v.exv;
      bus.ex_sets_flags = v.exsf;
      bus.flush         = v.fl;
      bus.alu_result    = v.res;
      bus.alu_op_a      = v.a;
      bus.alu_op_b      = v.b;
   endtask

   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      drive(v);
      sb.push_back(expect_of(v));
      #2;
      compare_outputs(tag);
   endtask

   task automatic push_reset_exp();
      exp_t x;
      x.z = 1'b1; x.n = 1'b0; x.e = 1'b0;
      x.rdy = 1'b1; x.stall = 1'b0; x.err = 1'b0;
      sb.push_back(x);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      drive(mk(0,0,0,0,0, 0,0,0, 0, 1,0,0, 1,0,0));
      repeat (2) @(posedge clk);
      push_reset_exp();
      #1;
      compare_outputs(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //           iss isf exv exsf fl res            a  b  pend z n e rdy stl err
      vecs[0]  = mk(1,1, 0,0, 0, 32'h0,          0, 0, 0,  1,0,0, 1,0,0);
      vecs[1]  = mk(0,0, 0,0, 0, 32'h0,          0, 0, 1,  1,0,0, 0,0,0);
      vecs[2]  = mk(0,0, 0,0, 0, 32'h0,          0, 0, 1,  1,0,0, 0,0,0);
      vecs[3]  = mk(0,0, 1,1, 0, 32'h8000_0000,  5, 5, 1,  1,0,0, 0,0,0);
      vecs[4]  = mk(0,0, 0,0, 0, 32'h0,          0, 0, 0,  0,1,1, 1,0,0);
      vecs[5]  = mk(1,1, 0,0, 0, 32'h0,          0, 0, 0,  0,1,1, 1,0,0);
      vecs[6]  = mk(1,1, 0,0, 0, 32'h0,          0, 0, 1,  0,1,1, 0,0,0);
      vecs[7]  = mk(1,1, 0,0, 0, 32'h0,          0, 0, 2,  0,1,1, 0,0,0);
      vecs[8]  = mk(0,0, 0,0, 0, 32'h0,          0, 0, 3,  0,1,1, 0,1,0);
      vecs[9]  = mk(1,1, 0,0, 0, 32'h0,          0, 0, 3,  0,1,1, 0,1,0);
      vecs[10] = mk(0,0, 0,0, 0, 32'h0,          0, 0, 3,  0,1,1, 0,1,1);
      vecs[11] = mk(0,0, 1,1, 0, 32'h5,          1, 2, 3,  0,1,1, 0,0,1);
      vecs[12] = mk(0,0, 1,1, 0, 32'h0,          0, 0, 2,  0,0,0, 0,0,1);
      vecs[13] = mk(1,1, 1,1, 0, 32'hFFFF_FFFF,  7, 7, 1,  1,0,1, 0,0,1);
      vecs[14] = mk(0,0, 0,0, 0, 32'h0,          0, 0, 1,  0,1,1, 0,0,1);
      vecs[15] = mk(1,1, 0,0, 0, 32'h0,          0, 0, 1,  0,1,1, 0,0,1);
      vecs[16] = mk(1,1, 1,1, 1, 32'h0,          1, 3, 2,  0,1,1, 0,0,1);
      vecs[17] = mk(0,0, 0,0, 0, 32'h0,          0, 0, 0,  1,0,0, 1,0,1);
      vecs[18] = mk(0,0, 0,0, 0, 32'h0,          0, 0, 0,  1,0,0, 1,0,1);

      do_reset("reset");
      for (int i = 0; i < 19; i++) apply(vecs[i], $sformatf("vec%0d", i));

      // Unqualified issue/retire must not count, write flags or raise errors.
      do_reset("reset2");
      apply(mk(0,0, 1,0, 0, 32'h8000_0000, 1, 1, 0, 1,0,0, 1,0,0), "ex_no_set");
      apply(mk(1,0, 0,0, 0, 32'h0,         0, 0, 0, 1,0,0, 1,0,0), "id_no_set");
      apply(mk(0,0, 0,0, 0, 32'h0,         0, 0, 0, 1,0,0, 1,0,0), "idle_after_nonset");

      // Retire with nothing outstanding: flags still written, sticky error.
      apply(mk(0,0, 1,1, 0, 32'h1234,      9, 9, 0, 1,0,0, 1,0,0), "underflow");
      apply(mk(0,0, 0,0, 0, 32'h0,         0, 0, 0, 0,0,1, 1,0,1), "underflow_next");
      for (int k = 0; k < 3; k++)
         apply(mk(0,0, 0,0, 0, 32'h0, 0, 0, 0, 0,0,1, 1,0,1), $sformatf("err_sticky%0d", k));

      // Asynchronous reset mid-operation, away from any clock edge.
      apply(mk(1,1, 0,0, 0, 32'h0, 0, 0, 0, 0,0,1, 1,0,1), "pre_rst_issue0");
      apply(mk(1,1, 0,0, 0, 32'h0, 0, 0, 1, 0,0,1, 0,0,1), "pre_rst_issue1");
      @(negedge clk);
      drive(mk(0,0,0,0,0, 0,0,0, 0, 1,0,0, 1,0,0));
      #1;
      rst_n = 1'b0;
      push_reset_exp();
      #1;
      compare_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      apply(mk(0,0, 0,0, 0, 32'h0, 0, 0, 0, 1,0,0, 1,0,0), "after_async_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
